// File: rtl/irq_requester_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | irq_requester_if : source events, core clear/mask and request signals    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface irq_requester_if;
  logic [29:0] src_evt;
  logic [31:0] clr;
  logic        mask_we;
  logic [31:0] mask_wdata;
  logic [31:0] irq_out;
  logic [31:0] pending;
  logic        busy;

  modport master (
    output src_evt, clr, mask_we, mask_wdata,
    input  irq_out, pending, busy
  );

  modport slave (
    input  src_evt, clr, mask_we, mask_wdata,
    output irq_out, pending, busy
  );
endinterface
`default_nettype wire

// File: rtl/irq_requester.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | irq_requester : collects peripheral events, pulses them to core IRQ vector |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module irq_requester #(
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned RETRY_CYCLES = 256,
  parameter logic [31:0] LEVEL_MASK   = 32'h0
) (
  input  logic            clk,
  input  logic            rst,
  irq_requester_if.slave  bus
);

  localparam logic [31:0]        c_LINES      = 32'hFFFF_FFFC;
  localparam logic [29:0]        c_LEVEL      = LEVEL_MASK[31:2];
  localparam int unsigned        c_CNT_W      = (RETRY_CYCLES == 0) ? 1 : $clog2(RETRY_CYCLES + 1);
  localparam logic [c_CNT_W-1:0] c_RETRY_LAST = c_CNT_W'(RETRY_CYCLES - 1);
  localparam logic               c_RETRY_EN   = (RETRY_CYCLES != 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2
  } state_t;

  logic [29:0]        w_synced;
  logic [29:0]        w_det;
  logic [29:0]        r_prev;
  logic [29:0]        r_set;
  logic [31:0]        w_set;
  logic [31:0]        w_clr;
  logic [31:0]        w_new;
  logic [31:0]        w_fire;
  logic               w_retry_hit;
  logic [31:0]        r_pending;
  logic [31:0]        r_sent;
  logic [31:0]        r_mask;
  logic [31:0]        r_irq;
  logic [c_CNT_W-1:0] r_cnt;
  state_t             r_state;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign w_synced = bus.src_evt;
    end else begin : g_sync
      logic [29:0] r_sync [SYNC_STAGES];
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
        end else begin
          r_sync[0] <= bus.src_evt;
          for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
        end
      end
      assign w_synced = r_sync[SYNC_STAGES-1];
    end
  endgenerate

  // Detected set events are registered once more before reaching pending.
  assign w_det = (w_synced & ~r_prev & ~c_LEVEL) | (w_synced & c_LEVEL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prev <= '0;
      r_set  <= '0;
    end else begin
      r_prev <= w_synced;
      r_set  <= w_det;
    end
  end

  assign w_set = {r_set, 2'b00};
  assign w_clr = bus.clr & c_LINES;
  assign w_new = r_pending & r_mask & ~r_sent;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pending <= '0;
      r_mask    <= '0;
    end else begin
      r_pending <= (r_pending & ~w_clr) | w_set;
      if (bus.mask_we) r_mask <= bus.mask_wdata & c_LINES;
    end
  end

  // New requests outrank going idle, which outranks a retry of unacked lines.
  always_comb begin
    w_fire      = '0;
    w_retry_hit = c_RETRY_EN && (r_cnt == c_RETRY_LAST);
    if (r_state == IDLE || r_state == WAIT) begin
      if (|w_new) begin
        w_fire = w_new;
      end else if (r_state == WAIT && r_sent != '0 && w_retry_hit) begin
        w_fire = r_sent;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_irq   <= '0;
      r_sent  <= '0;
      r_cnt   <= '0;
    end else begin
      r_irq  <= w_fire;
      r_sent <= (r_sent | w_fire) & ~w_clr;
      case (r_state)
        IDLE: begin
          if (|w_fire) r_state <= SEND;
        end
        SEND: begin
          r_state <= WAIT;
          r_cnt   <= '0;
        end
        WAIT: begin
          if (|w_fire) begin
            r_state <= SEND;
          end else if (r_sent == '0) begin
            r_state <= IDLE;
          end else if (r_cnt != '1) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.irq_out = r_irq;
  assign bus.pending = r_pending;
  assign bus.busy    = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_irq_requester.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_irq_requester : vector table, directed corner cases, random vs model  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_irq_requester;

  localparam int          RETRY = 4;
  localparam logic [31:0] LINES = 32'hFFFF_FFFC;
  localparam logic [29:0] LVL   = 30'h20;  // line 7 (src_evt[5]) is level-sensitive

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  irq_requester_if bus();

  irq_requester #(
    .SYNC_STAGES  (2),
    .RETRY_CYCLES (RETRY),
    .LEVEL_MASK   (32'h0000_0080)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: history of sampled sources, pending/sent/mask vectors,
  // and the request schedule tracked as "edges since last pulse".
  logic [29:0] m_hist [4];
  logic [31:0] m_pend, m_sent, m_mask, m_irq;
  logic        m_busy;
  bit          m_active;
  int          m_since;

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_hist[i] = '0;
    m_pend = '0; m_sent = '0; m_mask = '0; m_irq = '0;
    m_busy = 1'b0; m_active = 1'b0; m_since = 1000;
  endtask

  task automatic model_tick();
    logic [29:0] s30;
    logic [31:0] setv, newv, fire, clrv;
    if (rst) begin
      model_reset();
      return;
    end
    // A source sampled at edge t reaches pending at edge t+3.
    s30  = (m_hist[2] & ~m_hist[3] & ~LVL) | (m_hist[2] & LVL);
    setv = {s30, 2'b00};
    m_hist[3] = m_hist[2];
    m_hist[2] = m_hist[1];
    m_hist[1] = m_hist[0];
    m_hist[0] = bus.src_evt;
    newv = m_pend & m_mask & ~m_sent;
    fire = '0;
    if (!m_active) begin
      if (newv != 0) fire = newv;
    end else if (m_since != 0) begin
      if (newv != 0)        fire = newv;
      else if (m_sent == 0) m_active = 1'b0;
      else if (m_since == RETRY) fire = m_sent;
    end
    if (fire != 0) begin
      m_active = 1'b1;
      m_since  = 0;
    end else if (m_since < 1000) begin
      m_since++;
    end
    clrv   = bus.clr & LINES;
    m_sent = (m_sent | fire) & ~clrv;
    m_pend = (m_pend & ~clrv) | setv;
    if (bus.mask_we) m_mask = bus.mask_wdata & LINES;
    m_irq  = fire;
    m_busy = m_active;
  endtask

  task automatic step();
    @(posedge clk);
    model_tick();
    #1;
    chk("model irq_out", bus.irq_out, m_irq);
    chk("model pending", bus.pending, m_pend);
    chk("model busy", {31'b0, bus.busy}, {31'b0, m_busy});
  endtask

  task automatic wait_irq(input string name, input logic [31:0] exp, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (bus.irq_out == 0 && n < 40);
    chk(name, bus.irq_out, exp);
  endtask

  task automatic async_reset();
    rst = 1'b1;
    #1;
    chk("async rst irq_out", bus.irq_out, 32'h0);
    chk("async rst pending", bus.pending, 32'h0);
    chk("async rst busy", {31'b0, bus.busy}, 32'h0);
    model_reset();
    step();
    rst = 1'b0;
  endtask

  typedef struct packed {
    logic [29:0] src;
    logic [31:0] clr;
    logic        we;
    logic [31:0] wd;
    logic [31:0] irq;
    logic [31:0] pend;
    logic        busy;
  } vec_t;

  function automatic vec_t mk(input logic [29:0] src, input logic [31:0] clr, input logic we,
                              input logic [31:0] wd, input logic [31:0] irq,
                              input logic [31:0] pend, input logic busy);
    mk = '{src, clr, we, wd, irq, pend, busy};
  endfunction

  vec_t tbl [19];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    tbl[0]  = mk(30'h0, 32'h0,  1'b1, 32'h4,  32'h0,  32'h0,  1'b0);
    tbl[1]  = mk(30'h1, 32'h0,  1'b0, 32'h0,  32'h0,  32'h0,  1'b0);
    tbl[2]  = mk(30'h0, 32'h0,  1'b0, 32'h0,  32'h0,  32'h0,  1'b0);
    tbl[3]  = mk(30'h0, 32'h0,  1'b0, 32'h0,  32'h0,  32'h0,  1'b0);
    tbl[4]  = mk(30'h0, 32'h0,  1'b0, 32'h0,  32'h0,  32'h4,  1'b0);
    tbl[5]  = mk(30'h0, 32'h0,  1'b0, 32'h0,  32'h4,  32'h4,  1'b1);
    tbl[6]  = mk(30'h0, 32'h0,  1'b0, 32'h0,  32'h0,  32'h4,  1'b1);
    tbl[7]  = mk(30'h0, 32'h4,  1'b0, 32'h0,  32'h0,  32'h0,  1'b1);
    tbl[8]  = mk(30'h0, 32'h0,  1'b0, 32'h0,  32'h0,  32'h0,  1'b0);
    tbl[9]  = mk(30'h0, 32'h0,  1'b1, 32'h0,  32'h0,  32'h0,  1'b0);
    tbl[10] = mk(30'h8, 32'h0,  1'b0, 32'h0,  32'h0,  32'h0,  1'b0);
    tbl[11] = mk(30'h0, 32'h0,  1'b0, 32'h0,  32'h0,  32'h0,  1'b0);
    tbl[12] = mk(30'h0, 32'h0,  1'b0, 32'h0,  32'h0,  32'h0,  1'b0);
    tbl[13] = mk(30'h0, 32'h0,  1'b0, 32'h0,  32'h0,  32'h20, 1'b0);
    tbl[14] = mk(30'h0, 32'h0,  1'b1, 32'h20, 32'h0,  32'h20, 1'b0);
    tbl[15] = mk(30'h0, 32'h0,  1'b0, 32'h0,  32'h20, 32'h20, 1'b1);
    tbl[16] = mk(30'h0, 32'h20, 1'b0, 32'h0,  32'h0,  32'h0,  1'b1);
    tbl[17] = mk(30'h0, 32'h0,  1'b0, 32'h0,  32'h0,  32'h0,  1'b0);
    tbl[18] = mk(30'h0, 32'h0,  1'b0, 32'h0,  32'h0,  32'h0,  1'b0);

    rst = 1'b1;
    bus.src_evt = '0; bus.clr = '0; bus.mask_we = 1'b0; bus.mask_wdata = '0;
    model_reset();
    step();
    step();
    chk("reset irq_out", bus.irq_out, 32'h0);
    chk("reset pending", bus.pending, 32'h0);
    chk("reset busy", {31'b0, bus.busy}, 32'h0);
    rst = 1'b0;

    // Edge delivery, clear, masked pending and late unmask
    for (int i = 0; i < 19; i++) begin
      bus.src_evt    = tbl[i].src;
      bus.clr        = tbl[i].clr;
      bus.mask_we    = tbl[i].we;
      bus.mask_wdata = tbl[i].wd;
      step();
      chk($sformatf("vec%0d irq_out", i), bus.irq_out, tbl[i].irq);
      chk($sformatf("vec%0d pending", i), bus.pending, tbl[i].pend);
      chk($sformatf("vec%0d busy", i), {31'b0, bus.busy}, {31'b0, tbl[i].busy});
    end
    bus.src_evt = '0; bus.clr = '0; bus.mask_we = 1'b0;

    // Retry of an unacked line every RETRY+1 cycles, stopped by clr
    bus.src_evt = 30'h8; step(); bus.src_evt = '0;
    wait_irq("retry first", 32'h20, n);
    wait_irq("retry second", 32'h20, n);
    chk("retry period a", 32'(n), 32'd5);
    wait_irq("retry third", 32'h20, n);
    chk("retry period b", 32'(n), 32'd5);
    bus.clr = 32'h20; step(); bus.clr = '0; step();
    chk("retry stop busy", {31'b0, bus.busy}, 32'h0);
    repeat (10) step();

    // New line while waiting: only the new bit is pulsed
    bus.mask_we = 1'b1; bus.mask_wdata = 32'h204; step(); bus.mask_we = 1'b0;
    bus.src_evt = 30'h1; step(); bus.src_evt = '0;
    wait_irq("line2 pulse", 32'h4, n);
    bus.src_evt = 30'h80; step(); bus.src_evt = '0;
    wait_irq("new only", 32'h200, n);
    bus.clr = 32'h204; step(); bus.clr = '0; step();
    chk("new only idle", {31'b0, bus.busy}, 32'h0);

    // Clear coinciding with a fresh set keeps the line pending and re-sends it
    bus.mask_we = 1'b1; bus.mask_wdata = 32'h10; step(); bus.mask_we = 1'b0;
    bus.src_evt = 30'h4; step(); bus.src_evt = '0;
    wait_irq("line4 pulse", 32'h10, n);
    bus.src_evt = 30'h4; step(); bus.src_evt = '0;
    step(); step();
    bus.clr = 32'h10; step(); bus.clr = '0;
    chk("set+clr pending", bus.pending, 32'h10);
    wait_irq("set+clr resend", 32'h10, n);
    bus.clr = 32'h10; step(); bus.clr = '0; step();
    chk("line4 idle", {31'b0, bus.busy}, 32'h0);

    // Level line, asynchronous reset mid-wait, core-owned clear bits
    bus.mask_we = 1'b1; bus.mask_wdata = 32'h80; step(); bus.mask_we = 1'b0;
    bus.src_evt = 30'h20;
    wait_irq("level pulse", 32'h80, n);
    step(); step();
    async_reset();
    bus.mask_we = 1'b1; bus.mask_wdata = 32'h80; step(); bus.mask_we = 1'b0;
    wait_irq("level after reset", 32'h80, n);
    bus.clr = 32'h3; step(); bus.clr = '0;
    chk("clr[1:0] no effect", bus.pending, 32'h80);
    bus.clr = 32'h80; step(); bus.clr = '0;
    chk("level clr pending", bus.pending, 32'h80);
    wait_irq("level redeliver", 32'h80, n);
    bus.src_evt = '0;
    repeat (6) step();
    bus.clr = 32'h80; step(); bus.clr = '0;
    repeat (3) step();
    chk("level drained pending", bus.pending, 32'h0);
    chk("level drained busy", {31'b0, bus.busy}, 32'h0);

    // Random traffic against the reference model
    for (int c = 0; c < 2000; c++) begin
      bus.src_evt    = 30'($urandom & $urandom & $urandom & $urandom);
      bus.clr        = ($urandom_range(0, 3) == 0) ? ($urandom & $urandom) : 32'h0;
      bus.mask_we    = ($urandom_range(0, 31) == 0);
      bus.mask_wdata = $urandom;
      if (c == 1000) async_reset();
      else step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
